// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared state/fault encodings and sizing helper for the brew sequencer
package coffee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CUP_WAIT,
        GRIND,
        HEAT,
        PUMP,
        DONE,
        FAULT
    } brew_state_t;

    typedef enum logic [1:0] {
        F_NONE     = 2'd0,
        F_CUP_TMO  = 2'd1,
        F_HEAT_TMO = 2'd2,
        F_CUP_LOST = 2'd3
    } fault_code_t;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/coffee_brew_seq.sv
// rtl/coffee_brew_seq.sv - cup/grind/heat/pump brew sequencer with timeout supervision
// Optional BREW_CNT_EN adds a saturating brew_count output of completed brews.
module coffee_brew_seq
    import coffee_pkg::*;
#(
    parameter int unsigned GRIND_CYC    = 8000,
    parameter int unsigned PUMP_CYC     = 40000,
    parameter int unsigned HEAT_TMO_CYC = 400000,
    parameter int unsigned CUP_TMO_CYC  = 200000
) (
    input  logic        clk4m,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        cup_present,
    input  logic        temp_ok,
    input  logic        fault_clr,
    output logic        grinder_on,
    output logic        heater_on,
    output logic        pump_on,
    output logic        busy,
    output logic        coffee_ready,
    output logic        fault,
    output logic [1:0]  fault_code
`ifdef BREW_CNT_EN
    ,
    output logic [15:0] brew_count
`endif
);

    localparam int unsigned CNT_MAX = max4(GRIND_CYC, PUMP_CYC, HEAT_TMO_CYC, CUP_TMO_CYC);
    localparam int          CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] GRIND_LAST = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] PUMP_LAST  = CNT_W'(PUMP_CYC - 1);
    localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CUP_LAST   = CNT_W'(CUP_TMO_CYC - 1);

    brew_state_t      state_q, state_d;
    fault_code_t      code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk4m or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= F_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // abort is tested first in every active state so it beats timeout, completion and cup loss
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CUP_WAIT;
            end
            CUP_WAIT: begin
                if (abort)                 state_d = IDLE;
                else if (cup_present)      state_d = GRIND;
                else if (cnt_q == CUP_LAST) begin
                    state_d = FAULT;
                    code_d  = F_CUP_TMO;
                end
            end
            GRIND: begin
                if (abort)                    state_d = IDLE;
                else if (cnt_q == GRIND_LAST) state_d = HEAT;
            end
            HEAT: begin
                if (abort)                  state_d = IDLE;
                else if (temp_ok)           state_d = PUMP;
                else if (cnt_q == HEAT_LAST) begin
                    state_d = FAULT;
                    code_d  = F_HEAT_TMO;
                end
            end
            PUMP: begin
                if (abort)             state_d = IDLE;
                else if (!cup_present) begin
                    state_d = FAULT;
                    code_d  = F_CUP_LOST;
                end else if (cnt_q == PUMP_LAST) state_d = DONE;
            end
            DONE: begin
                if (!cup_present) state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = IDLE;
                    code_d  = F_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only timed states count; the idle-type states park the counter at zero
        cnt_d = '0;
        if (state_d == state_q && state_q inside {CUP_WAIT, GRIND, HEAT, PUMP})
            cnt_d = cnt_q + 1'b1;
    end

    assign grinder_on   = (state_q == GRIND);
    assign heater_on    = (state_q == HEAT) || (state_q == PUMP);
    assign pump_on      = (state_q == PUMP);
    assign coffee_ready = (state_q == DONE);
    assign fault        = (state_q == FAULT);
    assign busy         = (state_q != IDLE);
    assign fault_code   = code_q;

`ifdef BREW_CNT_EN
    logic [15:0] brew_cnt_q, brew_cnt_d;

    always_comb begin
        brew_cnt_d = brew_cnt_q;
        if (state_q == PUMP && state_d == DONE && brew_cnt_q != 16'hFFFF)
            brew_cnt_d = brew_cnt_q + 16'd1;
    end

    always_ff @(posedge clk4m or posedge rst) begin
        if (rst) brew_cnt_q <= '0;
        else     brew_cnt_q <= brew_cnt_d;
    end

    assign brew_count = brew_cnt_q;
`endif

endmodule

// File: tb/tb_coffee_brew_seq.sv
// tb/tb_coffee_brew_seq.sv - scoreboard bench: phase-duration model feeds expected outputs per edge
module tb_coffee_brew_seq;

    localparam int G  = 4;
    localparam int P  = 6;
    localparam int HT = 10;
    localparam int CT = 8;

    // {busy, grinder, heater, pump, ready, fault, code[1:0]}
    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_CUP   = 8'b1000_0000;
    localparam logic [7:0] V_GRIND = 8'b1100_0000;
    localparam logic [7:0] V_HEAT  = 8'b1010_0000;
    localparam logic [7:0] V_PUMP  = 8'b1011_0000;
    localparam logic [7:0] V_DONE  = 8'b1000_1000;
    localparam logic [7:0] V_FAULT = 8'b1000_0100;

    logic clk4m = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, cup_present = 1'b0, temp_ok = 1'b0, fault_clr = 1'b0;
    logic grinder_on, heater_on, pump_on, busy, coffee_ready, fault;
    logic [1:0] fault_code;
`ifdef BREW_CNT_EN
    logic [15:0] brew_count;
`endif

    coffee_brew_seq #(
        .GRIND_CYC(G), .PUMP_CYC(P), .HEAT_TMO_CYC(HT), .CUP_TMO_CYC(CT)
    ) dut (
        .clk4m(clk4m), .rst(rst), .start(start), .abort(abort),
        .cup_present(cup_present), .temp_ok(temp_ok), .fault_clr(fault_clr),
        .grinder_on(grinder_on), .heater_on(heater_on), .pump_on(pump_on),
        .busy(busy), .coffee_ready(coffee_ready), .fault(fault),
        .fault_code(fault_code)
`ifdef BREW_CNT_EN
        , .brew_count(brew_count)
`endif
    );

    always #5 clk4m = ~clk4m;

    logic [7:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int model_brews = 0;

    function automatic logic [7:0] obs();
        return {busy, grinder_on, heater_on, pump_on, coffee_ready, fault, fault_code};
    endfunction

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk4m);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check8("outputs", obs(), e);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // c: edge at which the cup appears; tt: edges into HEAT when temp_ok rises;
    // lc: edges into PUMP when the cup is taken; k: FAULT cycles before fault_clr;
    // a: edge carrying an abort pulse (0 = none); s: edge carrying a stray start (0 = none)
    task automatic run_scn(input int c, input int tt, input int lc, input int k,
                           input int a, input int s);
        logic [7:0] ex[64];
        bit st[64], ab[64], clr[64];
        int g0, h0, p0, f, last, cupend, tmp_on;
        logic [1:0] code;
        bit hit_done;
        for (int i = 0; i < 64; i++) begin
            ex[i] = V_IDLE; st[i] = 0; ab[i] = 0; clr[i] = 0;
        end
        f = -1; last = 0; cupend = 1000; tmp_on = 1000; code = 2'd0;
        g0 = (c < 1) ? 1 : c;
        if (g0 > CT) begin
            for (int i = 0; i < CT; i++) ex[i] = V_CUP;
            f = CT; code = 2'd1;
        end else begin
            for (int i = 0; i < g0; i++) ex[i] = V_CUP;
            for (int i = g0; i < g0 + G; i++) ex[i] = V_GRIND;
            h0 = g0 + G;
            if (tt > HT) begin
                for (int i = h0; i < h0 + HT; i++) ex[i] = V_HEAT;
                f = h0 + HT; code = 2'd2;
            end else begin
                for (int i = h0; i < h0 + tt; i++) ex[i] = V_HEAT;
                tmp_on = h0 + tt;
                p0 = h0 + tt;
                cupend = p0 + lc;
                if (lc <= P) begin
                    for (int i = p0; i < p0 + lc; i++) ex[i] = V_PUMP;
                    f = p0 + lc; code = 2'd3;
                end else begin
                    for (int i = p0; i < p0 + P; i++) ex[i] = V_PUMP;
                    for (int i = p0 + P; i < p0 + lc; i++) ex[i] = V_DONE;
                    last = p0 + lc;
                end
            end
        end
        if (f >= 0) begin
            for (int i = f; i < f + k; i++) ex[i] = V_FAULT | {6'd0, code};
            clr[f + k] = 1;
            last = f + k;
        end
        if (a > 0 && a <= last) begin
            ab[a] = 1;
            if (ex[a-1][7] && !ex[a-1][3] && !ex[a-1][2]) begin
                for (int i = a; i < 64; i++) ex[i] = V_IDLE;
                last = a;
            end
        end
        if (s > 0 && s <= last && ex[s-1][7]) st[s] = 1;
        st[0] = 1;
        hit_done = 0;
        for (int i = 0; i <= last; i++) if (ex[i] == V_DONE) hit_done = 1;
        if (hit_done && model_brews < 65535) model_brews++;

        for (int n = 0; n <= last + 2; n++) begin
            start       = st[n];
            abort       = ab[n];
            fault_clr   = clr[n];
            cup_present = (n >= c) && (n < cupend);
            temp_ok     = (n >= tmp_on);
            @(posedge clk4m);
            #1;
            exp_q.push_back(ex[n]);
        end
        start = 0; abort = 0; fault_clr = 0; cup_present = 0; temp_ok = 0;
        @(negedge clk4m);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
`ifdef BREW_CNT_EN
        n_chk++;
        if (brew_count == 16'(model_brews)) n_pass++;
        else $display("FAIL brew_count: got %0d expected %0d", brew_count, model_brews);
`endif
    endtask

    initial begin : stim
        #2 rst = 1;
        #2;
        check8("reset_async", obs(), V_IDLE);
        repeat (2) @(posedge clk4m);
        #1 rst = 0;
        @(negedge clk4m);
        check8("reset_idle", obs(), V_IDLE);

        // reset mid-PUMP: actuators must drop without a clock edge
        start = 1; cup_present = 1; temp_ok = 1;
        @(posedge clk4m);
        #1 start = 0;
        repeat (7) @(posedge clk4m);
        @(negedge clk4m);
        check8("pre_reset_pump", obs(), V_PUMP);
        #1 rst = 1;
        #1;
        check8("reset_mid_pump", obs(), V_IDLE);
        @(posedge clk4m);
        #1 rst = 0; cup_present = 0; temp_ok = 0;
        model_brews = 0;

        run_scn(0, 1, P + 2, 1, 0, 0);        // normal brew
        run_scn(0, 1, P + 1, 1, 0, 0);        // second normal brew, cup taken right after DONE
        run_scn(99, 1, 1, 2, 0, 0);           // cup timeout
        run_scn(CT, 1, P + 2, 1, 0, 0);       // cup arrives on the timeout edge
        run_scn(0, 99, 1, 1, 0, 0);           // heat timeout
        run_scn(0, HT, P + 2, 1, 0, 0);       // temp_ok on the timeout edge
        run_scn(0, 1, 3, 2, 0, 0);            // cup lost in third PUMP cycle
        run_scn(0, 1, P, 1, 0, 0);            // cup lost on the completion edge
        run_scn(0, 1, P + 3, 1, 2, 0);        // abort in GRIND
        run_scn(0, 99, 1, 1, 1 + G + HT, 0);  // abort coincident with heat timeout
        run_scn(99, 1, 1, 1, CT, 0);          // abort coincident with cup timeout
        run_scn(0, 1, P + 2, 1, 0, 1 + G + 1 + 2); // start during PUMP ignored
        run_scn(0, 1, P + 4, 1, 1 + G + 1 + P + 1, 0); // abort in DONE ignored
        run_scn(99, 1, 1, 3, CT + 1, 0);      // abort in FAULT ignored

        for (int r = 0; r < 40; r++) begin
            run_scn($urandom_range(0, CT + 2), $urandom_range(1, HT + 2),
                    $urandom_range(1, P + 4), $urandom_range(1, 3),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
